// File: rtl/bullet_pool_ctrl_if.sv
// Bundle between the bullet pool and its requesters / draw logic.
// Handshake: fire_req[k] is a level held until the one-cycle fire_gnt[k] pulse; the grant
// appears one clock after the request is sampled, and the bullet is live in that same cycle.
interface bullet_pool_ctrl_if #(
  parameter int NSLOT = 4
);
  logic                   move_tick;
  logic [1:0]             fire_req;
  logic [9:0]             fire_x0;
  logic [9:0]             fire_y0;
  logic [9:0]             fire_x1;
  logic [9:0]             fire_y1;
  logic [NSLOT-1:0]       hit;
  logic [1:0]             fire_gnt;
  logic [NSLOT-1:0]       slot_valid;
  logic [NSLOT-1:0]       slot_dir;
  logic [NSLOT*10-1:0]    slot_x;
  logic [NSLOT*10-1:0]    slot_y;
  logic                   pool_full;

  modport master (
    output move_tick, fire_req, fire_x0, fire_y0, fire_x1, fire_y1, hit,
    input  fire_gnt, slot_valid, slot_dir, slot_x, slot_y, pool_full
  );

  modport slave (
    input  move_tick, fire_req, fire_x0, fire_y0, fire_x1, fire_y1, hit,
    output fire_gnt, slot_valid, slot_dir, slot_x, slot_y, pool_full
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// Bullet slot pool: round-robin fire arbitration between player and enemy,
// lowest-free-slot allocation, per-tick movement and retirement on hit or screen exit.
module bullet_pool_ctrl #(
  parameter int NSLOT    = 4,
  parameter int STEP     = 2,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int COOLDOWN = 3
) (
  input  logic              clk,
  input  logic              rst,
  bullet_pool_ctrl_if.slave bus
);
  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int SW = (NSLOT < 2) ? 1 : $clog2(NSLOT);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [10:0]   UP_LIM  = 11'(Y_MIN + STEP);
  localparam logic [10:0]   DN_LIM  = 11'(Y_MAX);
  localparam logic [10:0]   STEP11  = 11'(STEP);

  logic [NSLOT-1:0] valid_q;
  logic [NSLOT-1:0] dir_q;
  logic [9:0]       x_q [NSLOT];
  logic [9:0]       y_q [NSLOT];
  logic [1:0]       gnt_q;
  logic [CW-1:0]    cd_q [2];
  logic             rr_q;

  logic [1:0]       elig;
  logic             any_free;
  logic             grant_en;
  logic             win;
  logic [SW-1:0]    alloc_idx;

  // The free mask is taken from registered valid, so a slot freed this edge waits a cycle.
  always_comb begin
    elig[0]   = bus.fire_req[0] && (cd_q[0] == '0);
    elig[1]   = bus.fire_req[1] && (cd_q[1] == '0);
    any_free  = ~(&valid_q);
    grant_en  = any_free && (|elig);
    win       = (&elig) ? rr_q : elig[1];
    alloc_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = SW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= '0;
      rr_q    <= 1'b0;
      cd_q[0] <= '0;
      cd_q[1] <= '0;
    end else begin
      gnt_q <= '0;
      if (grant_en) begin
        gnt_q[win] <= 1'b1;
        rr_q       <= ~win;
      end
      for (int k = 0; k < 2; k++) begin
        if (grant_en && (win == 1'(k))) begin
          cd_q[k] <= CD_LOAD;
        end else if (bus.move_tick && (cd_q[k] != '0)) begin
          cd_q[k] <= cd_q[k] - 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    logic        v_r;
    logic        d_r;
    logic [9:0]  x_r;
    logic [9:0]  y_r;
    logic        spawn;
    logic [10:0] y_ext;

    assign spawn = grant_en && (alloc_idx == SW'(i));
    assign y_ext = {1'b0, y_r};

    // Spawning only targets a free slot, so it never competes with hit or movement.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_r <= 1'b0;
        d_r <= 1'b0;
        x_r <= '0;
        y_r <= '0;
      end else if (spawn) begin
        v_r <= 1'b1;
        d_r <= win;
        x_r <= win ? bus.fire_x1 : bus.fire_x0;
        y_r <= win ? bus.fire_y1 : bus.fire_y0;
      end else if (v_r) begin
        if (bus.hit[i]) begin
          v_r <= 1'b0;
        end else if (bus.move_tick) begin
          if (!d_r) begin
            if (y_ext < UP_LIM) v_r <= 1'b0;
            else                y_r <= 10'(y_ext - STEP11);
          end else begin
            if ((y_ext + STEP11) > DN_LIM) v_r <= 1'b0;
            else                           y_r <= 10'(y_ext + STEP11);
          end
        end
      end
    end

    assign valid_q[i]           = v_r;
    assign dir_q[i]             = d_r;
    assign x_q[i]               = x_r;
    assign y_q[i]               = y_r;
    assign bus.slot_x[10*i +: 10] = x_r;
    assign bus.slot_y[10*i +: 10] = y_r;
  end

  assign bus.slot_valid = valid_q;
  assign bus.slot_dir   = dir_q;
  assign bus.fire_gnt   = gnt_q;
  assign bus.pool_full  = &valid_q;
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Bench for bullet_pool_ctrl: directed scenarios plus random traffic, scored against
// a slot-list reference model through an expected-state queue and a grant-event queue.
module tb_bullet_pool_ctrl;
  localparam int NSLOT    = 4;
  localparam int STEP     = 2;
  localparam int Y_MIN    = 0;
  localparam int Y_MAX    = 479;
  localparam int COOLDOWN = 3;
  localparam int W        = 3 + 2 * NSLOT + 20 * NSLOT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   release_pending = 1'b0;

  bullet_pool_ctrl_if #(.NSLOT(NSLOT)) bus();

  bullet_pool_ctrl #(
    .NSLOT(NSLOT), .STEP(STEP), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_valid [NSLOT];
  bit         m_dir   [NSLOT];
  int         m_x     [NSLOT];
  int         m_y     [NSLOT];
  int         m_cd    [2];
  int         m_rr;
  logic [1:0] m_gnt;

  logic [W-1:0] exp_q[$];
  logic [3:0]   gnt_q[$];

  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) begin
      m_valid[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd[0] = 0; m_cd[1] = 0; m_rr = 0; m_gnt = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] req, input logic [9:0] x0, input logic [9:0] y0,
                            input logic [9:0] x1, input logic [9:0] y1,
                            input logic [NSLOT-1:0] h, input logic tick);
    int free_slot;
    int winner;
    bit el0, el1;
    free_slot = -1;
    winner    = -1;
    el0 = req[0] && (m_cd[0] == 0);
    el1 = req[1] && (m_cd[1] == 0);
    for (int i = 0; i < NSLOT; i++)
      if (!m_valid[i] && free_slot < 0) free_slot = i;
    if (free_slot >= 0) begin
      if (el0 && el1)  winner = m_rr;
      else if (el0)    winner = 0;
      else if (el1)    winner = 1;
    end
    for (int k = 0; k < 2; k++) begin
      if (winner == k)             m_cd[k] = COOLDOWN;
      else if (tick && m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (m_valid[i]) begin
        if (h[i]) m_valid[i] = 0;
        else if (tick) begin
          if (!m_dir[i]) begin
            if (m_y[i] - STEP < Y_MIN) m_valid[i] = 0;
            else                       m_y[i] = m_y[i] - STEP;
          end else begin
            if (m_y[i] + STEP > Y_MAX) m_valid[i] = 0;
            else                       m_y[i] = m_y[i] + STEP;
          end
        end
      end
    end
    m_gnt = 2'b00;
    if (winner >= 0) begin
      m_rr = 1 - winner;
      m_valid[free_slot] = 1;
      m_dir[free_slot]   = (winner == 1);
      m_x[free_slot]     = (winner == 1) ? int'(x1) : int'(x0);
      m_y[free_slot]     = (winner == 1) ? int'(y1) : int'(y0);
      m_gnt[winner]      = 1'b1;
      gnt_q.push_back({(winner == 1), 3'(free_slot)});
    end
  endtask

  function automatic logic [W-1:0] model_snap();
    logic [NSLOT-1:0]    v, d;
    logic [10*NSLOT-1:0] xs, ys;
    logic                full;
    full = 1'b1;
    for (int i = 0; i < NSLOT; i++) begin
      v[i] = m_valid[i];
      d[i] = m_dir[i];
      xs[10*i +: 10] = 10'(m_x[i]);
      ys[10*i +: 10] = 10'(m_y[i]);
      if (!m_valid[i]) full = 1'b0;
    end
    return {m_gnt, full, v, d, xs, ys};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [1:0]          e_gnt;
    logic                e_full;
    logic [NSLOT-1:0]    e_v, e_d;
    logic [10*NSLOT-1:0] e_x, e_y;
    logic [3:0]          ge;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        {e_gnt, e_full, e_v, e_d, e_x, e_y} = exp_q.pop_front();
        check("fire_gnt",   bus.fire_gnt,   e_gnt);
        check("pool_full",  bus.pool_full,  e_full);
        check("slot_valid", bus.slot_valid, e_v);
        check("slot_dir",   bus.slot_dir,   e_d);
        check("slot_x",     bus.slot_x,     e_x);
        check("slot_y",     bus.slot_y,     e_y);
      end
      if (rst && bus.fire_gnt != 2'b00) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", bus.fire_gnt, 2'b00);
        end else begin
          ge = gnt_q.pop_front();
          check("gnt_who",        bus.fire_gnt, ge[3] ? 2'b10 : 2'b01);
          check("gnt_slot_valid", bus.slot_valid[ge[2:0]], 1'b1);
          check("gnt_slot_dir",   bus.slot_dir[ge[2:0]],   ge[3]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] req, input logic [9:0] x0, input logic [9:0] y0,
                      input logic [9:0] x1, input logic [9:0] y1,
                      input logic [NSLOT-1:0] h, input logic tick);
    @(negedge clk);
    if (release_pending) begin
      rst = 1'b1;
      release_pending = 1'b0;
    end
    bus.fire_req  = req;
    bus.fire_x0   = x0;
    bus.fire_y0   = y0;
    bus.fire_x1   = x1;
    bus.fire_y1   = y1;
    bus.hit       = h;
    bus.move_tick = tick;
    model_step(req, x0, y0, x1, y1, h, tick);
    exp_q.push_back(model_snap());
  endtask

  task automatic idle(input logic tick);
    step(2'b00, 10'd0, 10'd0, 10'd0, 10'd0, '0, tick);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.slot_valid, 0);
    check({tag, "_dir"},   bus.slot_dir,   0);
    check({tag, "_x"},     bus.slot_x,     0);
    check({tag, "_y"},     bus.slot_y,     0);
    check({tag, "_gnt"},   bus.fire_gnt,   0);
    check({tag, "_full"},  bus.pool_full,  0);
  endtask

  // Asserts reset between edges and expects the outputs to clear without a clock edge.
  task automatic do_reset_async(input logic [1:0] hold_req);
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.fire_req  = hold_req;
    bus.move_tick = 1'b0;
    bus.hit       = '0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    gnt_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    release_pending = 1'b1;
  endtask

  function automatic logic [9:0] rand_y();
    case ($urandom_range(0, 3))
      0:       return 10'($urandom_range(0, 5));
      1:       return 10'($urandom_range(474, 479));
      default: return 10'($urandom_range(0, 479));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [1:0]       req;
    logic [NSLOT-1:0] h;
    bus.fire_req = 2'b00; bus.move_tick = 1'b0; bus.hit = '0;
    bus.fire_x0 = '0; bus.fire_y0 = '0; bus.fire_x1 = '0; bus.fire_y1 = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    release_pending = 1'b1;

    // Player spawn, then three ticks upward.
    step(2'b01, 10'd100, 10'd400, 10'd0, 10'd0, '0, 1'b0);
    sample();
    check("t1_gnt", bus.fire_gnt, 2'b01);
    check("t1_x", bus.slot_x[9:0], 100);
    check("t1_y", bus.slot_y[9:0], 400);
    idle(1'b1); idle(1'b1); idle(1'b1);
    sample();
    check("t1_y_after3", bus.slot_y[9:0], 394);

    // Both requesting from reset: player, enemy, then nothing while cooling down.
    do_reset_async(2'b11);
    step(2'b11, 10'd10, 10'd300, 10'd20, 10'd50, '0, 1'b0);
    sample();
    check("t2_gnt0", bus.fire_gnt, 2'b01);
    step(2'b11, 10'd10, 10'd300, 10'd20, 10'd50, '0, 1'b0);
    sample();
    check("t2_gnt1", bus.fire_gnt, 2'b10);
    step(2'b11, 10'd10, 10'd300, 10'd20, 10'd50, '0, 1'b0);
    sample();
    check("t2_gnt2", bus.fire_gnt, 2'b00);
    check("t2_dirs", bus.slot_dir[1:0], 2'b10);

    // Fill the pool, free slot 2 with a hit, and watch it refill.
    do_reset_async(2'b00);
    for (int c = 0; c < 40; c++)
      step(2'b11, 10'd50, 10'd240, 10'd60, 10'd240, '0, (c % 4 == 3));
    sample();
    check("t3_full", bus.pool_full, 1'b1);
    step(2'b11, 10'd50, 10'd240, 10'd60, 10'd240, 4'b0100, 1'b0);
    for (int c = 0; c < 3; c++)
      step(2'b11, 10'd50, 10'd240, 10'd60, 10'd240, '0, 1'b0);
    sample();
    check("t3_refill", bus.slot_valid, 4'hf);

    // Screen-edge retirement in both directions.
    do_reset_async(2'b00);
    step(2'b01, 10'd30, 10'd3, 10'd0, 10'd0, '0, 1'b0);
    idle(1'b1);
    sample();
    check("t4_up_y1", bus.slot_y[9:0], 1);
    idle(1'b1);
    sample();
    check("t4_up_retired", bus.slot_valid[0], 1'b0);
    step(2'b10, 10'd0, 10'd0, 10'd40, 10'd476, '0, 1'b0);
    idle(1'b1);
    sample();
    check("t4_dn_y478", bus.slot_y[9:0], 478);
    idle(1'b1);
    sample();
    check("t4_dn_retired", bus.slot_valid[0], 1'b0);

    // Hit coinciding with a tick, then a spawn coinciding with a tick.
    do_reset_async(2'b00);
    step(2'b01, 10'd70, 10'd200, 10'd80, 10'd200, '0, 1'b0);
    step(2'b10, 10'd70, 10'd200, 10'd80, 10'd200, '0, 1'b0);
    step(2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 4'b0010, 1'b1);
    sample();
    check("t5_hit_valid", bus.slot_valid, 4'b0001);
    check("t5_hit_y", bus.slot_y[19:10], 200);
    idle(1'b1); idle(1'b1); idle(1'b1);
    step(2'b10, 10'd0, 10'd0, 10'd90, 10'd100, '0, 1'b1);
    sample();
    check("t5_spawn_y", bus.slot_y[19:10], 100);
    step(2'b01, 10'd15, 10'd250, 10'd0, 10'd0, '0, 1'b0);
    sample();
    check("t6_three_live", bus.slot_valid, 4'b0111);
    do_reset_async(2'b11);

    // Random traffic.
    req = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset_async(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      for (int i = 0; i < NSLOT; i++) h[i] = ($urandom_range(0, 15) == 0);
      step(req, 10'($urandom_range(0, 639)), rand_y(), 10'($urandom_range(0, 639)), rand_y(),
           h, ($urandom_range(0, 2) == 0));
    end
    idle(1'b0);
    repeat (3) sample();
    check("exp_q_drained", exp_q.size(), 0);
    check("gnt_q_drained", gnt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bullet_pool_ctrl.md
Name: bullet_pool_ctrl

Overview:
- Owns a fixed pool of bullet slots and shares them between two fire requesters: player (req 0) and enemy (req 1).
- Arbitrates fire requests round-robin and allocates the lowest free slot.
- Advances every live bullet on each movement tick and retires bullets on collision or screen exit.
- Per-slot position/valid outputs feed the VGA draw and collision logic downstream.

Parameters:
NSLOT, 4, number of bullet slots (2..8)
STEP, 2, pixels moved per move_tick
Y_MIN, 0, top retire limit (up-moving bullets)
Y_MAX, 479, bottom retire limit (down-moving bullets)
COOLDOWN, 3, move_ticks a requester is blocked after a grant

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
move_tick  in  1  one-cycle strobe, movement step (game-speed clock domain already synchronised)
fire_req  in  2  level request; bit0 player, bit1 enemy; held until granted
fire_x0, fire_y0  in  10 each  spawn point for requester 0
fire_x1, fire_y1  in  10 each  spawn point for requester 1
hit  in  NSLOT  per-slot collision pulse
fire_gnt  out  2  registered one-hot grant pulse
slot_valid  out  NSLOT  slot holds a live bullet
slot_dir  out  NSLOT  0 = moving up (player), 1 = moving down (enemy)
slot_x  out  NSLOT*10  packed x, slot i at [10i+9:10i]
slot_y  out  NSLOT*10  packed y, same packing
pool_full  out  1  all slots valid (combinational from slot_valid)

Behaviour:
- Reset (rst low, async): slot_valid=0, slot_x/y/dir=0, fire_gnt=0, cooldowns=0, RR pointer=0 (player first).
- Eligible requester: fire_req bit set and its cooldown==0.
- Arbitration, evaluated each clk:
  - One grant max per cycle, and only if some slot is free in the current registered slot_valid.
  - Both eligible: RR pointer side wins; pointer then flips to the other side. Single eligible: it wins; pointer flips away from the winner.
- Allocation, on the grant edge:
  - Target is the lowest-index free slot.
  - slot_valid<=1, x/y<=winner's spawn point, dir<=winner index.
  - fire_gnt bit <=1 for exactly one cycle (latency 1 from the sampled request).
  - Winner cooldown<=COOLDOWN.
- Cooldown: each nonzero counter decrements by 1 on move_tick. A grant edge coinciding with move_tick loads COOLDOWN, with no decrement that cycle.
- Movement, on move_tick for each valid slot not being hit:
  - dir=0: if y < Y_MIN+STEP then retire (valid<=0), else y<=y-STEP.
  - dir=1: if y+STEP > Y_MAX then retire, else y<=y+STEP.
  - Compare in 11 bits; no wrap-around is ever produced. x never changes.
- Hit: hit[i] with slot_valid[i] clears valid at the next edge. Hit has priority over movement. hit on an invalid slot is ignored.
- Simultaneous events:
  - Freed slot: a slot freed (hit/retire) this cycle is not allocatable until the next cycle, because the free mask comes from registered state.
  - Same-edge spawn + move_tick: the newly allocated bullet is placed at its spawn point unmoved.
  - pool_full=1: requests stay pending, no grant, and the RR pointer is unchanged.
- Invalid slots retain their last x/y/dir; consumers gate on slot_valid.
- Reset asserted mid-flight clears all slots immediately. A pending request is re-arbitrated from pointer=0 after release.

Test Plan:
- Reset then fire_req=01, fire_x0=100, fire_y0=400 held → next cycle fire_gnt=01, slot0 valid, x=100, y=400, dir=0. Drop req; 3 move_ticks → slot0 y=394.
- fire_req=11 from reset, cooldowns 0 → grants 01 then 10 on consecutive cycles; slot0 dir=0, slot1 dir=1. A third cycle gives no grant (both cooling down).
- Player req held continuously with move_tick every 4 clk → grants separated by exactly 3 move_ticks. Fill 4 slots (alternate requesters) → pool_full=1 and no 5th grant. Pulse hit[2] → slot2 freed, refilled on the cycle after it clears.
- Up bullet at y=3 with move_tick → y=1. Next move_tick → retired (1 < 0+2). Down bullet spawned at y=476 → 478, then retired on next tick (480 > 479).
- hit[1] and move_tick on the same edge → slot1 invalid, y unchanged. Spawn coinciding with move_tick → new slot holds the unmoved spawn y.
- Assert rst low asynchronously between edges while 3 bullets are live → all outputs 0 immediately, with no clk edge needed.
